// File: rtl/ps2_key_capture.sv
// PS/2 keyboard receiver: synchronizes and filters the line, deframes 11-bit frames and
// folds scan-code-set-2 E0/F0 prefixes into a toggling 11-bit key event word.
module ps2_key_capture #(
    parameter int unsigned FILTER  = 4,
    parameter int unsigned TIMEOUT = 12000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    output logic [10:0] ps2_key,
    output logic        frame_err,
    output logic        busy
);

    localparam int unsigned FiltW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int unsigned WdogW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [FiltW-1:0] FiltMax = FiltW'(FILTER - 1);
    localparam logic [WdogW-1:0] WdogMax = WdogW'(TIMEOUT - 1);

    logic             clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
    logic             clk_filt_q, clk_filt_d;
    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [WdogW-1:0] wdog_q, wdog_d;
    logic             ext_q, ext_d, brk_q, brk_d;
    logic [10:0]      key_q, key_d;
    logic             err_q, err_d;
    logic             strobe, byte_ok;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_i;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= ps2_data_i;
            data_sync_q <= data_meta_q;
        end
    end

    // Level changes only after FILTER consecutive disagreeing samples.
    always_comb begin
        clk_filt_d = clk_filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q != clk_filt_q) begin
            if (filt_cnt_q == FiltMax) begin
                clk_filt_d = clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign strobe = clk_filt_q & ~clk_filt_d;

    always_comb begin
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        wdog_d   = wdog_q;
        ext_d    = ext_q;
        brk_d    = brk_q;
        key_d    = key_q;
        err_d    = 1'b0;
        byte_ok  = 1'b0;
        if (strobe) begin
            wdog_d = '0;
            if (bitcnt_q == 4'd0) begin
                if (!data_sync_q) bitcnt_d = 4'd1;
            end else if (bitcnt_q <= 4'd8) begin
                shift_d  = {data_sync_q, shift_q[7:1]};
                bitcnt_d = bitcnt_q + 4'd1;
            end else if (bitcnt_q == 4'd9) begin
                par_d    = data_sync_q;
                bitcnt_d = 4'd10;
            end else begin
                bitcnt_d = 4'd0;
                if (((^shift_q) ^ par_q) && data_sync_q) begin
                    byte_ok = 1'b1;
                end else begin
                    err_d = 1'b1;
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            end
        end else if (bitcnt_q != 4'd0) begin
            // Expiry lands on the edge where the count would reach TIMEOUT.
            if (wdog_q == WdogMax) begin
                wdog_d   = '0;
                bitcnt_d = 4'd0;
                err_d    = 1'b1;
                ext_d    = 1'b0;
                brk_d    = 1'b0;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end else begin
            wdog_d = '0;
        end

        if (byte_ok) begin
            case (shift_q)
                8'hE0: ext_d = 1'b1;
                8'hF0: brk_d = 1'b1;
                8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
                default: begin
                    key_d = {~key_q[10], ~brk_q, ext_q, shift_q};
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_filt_q <= 1'b1;
            filt_cnt_q <= '0;
            bitcnt_q   <= 4'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            wdog_q     <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            key_q      <= 11'h000;
            err_q      <= 1'b0;
        end else begin
            clk_filt_q <= clk_filt_d;
            filt_cnt_q <= filt_cnt_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            wdog_q     <= wdog_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            key_q      <= key_d;
            err_q      <= err_d;
        end
    end

    assign ps2_key   = key_q;
    assign frame_err = err_q;
    assign busy      = (bitcnt_q != 4'd0);

endmodule

// File: tb/tb_ps2_key_capture.sv
// Directed bench for ps2_key_capture: expected key words are queued as frames are sent
// and popped by a monitor whenever the DUT key word changes.
module tb_ps2_key_capture;

    localparam int unsigned FILTER  = 4;
    localparam int unsigned TIMEOUT = 300;
    localparam int          HALF    = 20;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int          err_pulses = 0;
    int          err_len = 0;
    logic [10:0] prev_key = 11'h000;
    logic [10:0] exp_q[$];

    ps2_key_capture #(
        .FILTER (FILTER),
        .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_clk_i (ps2_clk),
        .ps2_data_i(ps2_data),
        .ps2_key   (ps2_key),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: every key change must match the next queued word.
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            prev_key = ps2_key;
            err_len  = 0;
        end else begin
            if (ps2_key !== prev_key) begin
                if (exp_q.size() == 0) check("key_unexpected", 32'(ps2_key), 32'(prev_key));
                else check("key_event", 32'(ps2_key), 32'(exp_q.pop_front()));
                prev_key = ps2_key;
            end
            if (frame_err) begin
                if (err_len == 0) err_pulses++;
                err_len++;
            end else if (err_len != 0) begin
                check("err_width", err_len, 1);
                err_len = 0;
            end
        end
    end

    // Sends the first nbits of a frame; glitch>=0 puts a 2-cycle low pulse in that bit's high phase.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_v,
                              input int nbits, input int glitch);
        logic [10:0] fr;
        fr = {stop_v, ~(^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            if (i == glitch) begin
                repeat (5) @(negedge clk_sys);
                ps2_clk = 1'b0;
                repeat (2) @(negedge clk_sys);
                ps2_clk = 1'b1;
                repeat (HALF - 7) @(negedge clk_sys);
            end else begin
                repeat (HALF) @(negedge clk_sys);
            end
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk_sys);
            if (i == 5) check("busy_mid_frame", 32'(busy), 1);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk_sys);
        if (nbits == 11) check("busy_after_frame", 32'(busy), 0);
    endtask

    task automatic drained(input string tag, input int exp_err);
        repeat (10) @(negedge clk_sys);
        check({tag, "_queue"}, exp_q.size(), 0);
        check({tag, "_errs"}, err_pulses, exp_err);
    endtask

    initial begin
        int  c;
        logic found;
        reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("rst_key", 32'(ps2_key), 0);
        check("rst_err", 32'(frame_err), 0);
        check("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);

        exp_q.push_back(11'h629);
        send_frame(8'h29, 1'b0, 1'b1, 11, -1);
        drained("make", 0);

        send_frame(8'hF0, 1'b0, 1'b1, 11, -1);
        drained("break_prefix", 0);
        exp_q.push_back(11'h029);
        send_frame(8'h29, 1'b0, 1'b1, 11, -1);
        drained("break", 0);

        send_frame(8'hE0, 1'b0, 1'b1, 11, -1);
        exp_q.push_back(11'h775);
        send_frame(8'h75, 1'b0, 1'b1, 11, -1);
        drained("ext_make", 0);

        send_frame(8'hE0, 1'b0, 1'b1, 11, -1);
        send_frame(8'hF0, 1'b0, 1'b1, 11, -1);
        exp_q.push_back(11'h175);
        send_frame(8'h75, 1'b0, 1'b1, 11, -1);
        drained("ext_break", 0);

        send_frame(8'hFA, 1'b0, 1'b1, 11, -1);
        drained("discard", 0);
        check("discard_key", 32'(ps2_key), 32'h175);

        send_frame(8'hF0, 1'b0, 1'b1, 11, -1);
        send_frame(8'h29, 1'b1, 1'b1, 11, -1);
        drained("parity_err", 1);
        check("parity_key", 32'(ps2_key), 32'h175);
        exp_q.push_back(11'h629);
        send_frame(8'h29, 1'b0, 1'b1, 11, -1);
        drained("after_err", 1);

        send_frame(8'h29, 1'b0, 1'b0, 11, -1);
        ps2_data = 1'b1;
        drained("stop_err", 2);

        // Timeout: five bits, the fifth falling edge is timed manually.
        send_frame(8'h00, 1'b0, 1'b1, 4, -1);
        ps2_data = 1'b0;
        repeat (HALF) @(negedge clk_sys);
        ps2_clk = 1'b0;
        c = 0;
        found = 1'b0;
        while (c < int'(TIMEOUT) + 50 && !found) begin
            @(negedge clk_sys);
            c++;
            if (c == HALF) ps2_clk = 1'b1;
            if (c == HALF + 5) check("busy_before_timeout", 32'(busy), 1);
            if (frame_err) found = 1'b1;
        end
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        check("timeout_seen", 32'(found), 1);
        check("timeout_cycles", 32'(c >= int'(TIMEOUT + FILTER) + 1 &&
                                    c <= int'(TIMEOUT + FILTER) + 3), 1);
        check("timeout_busy", 32'(busy), 0);
        drained("timeout", 3);

        exp_q.push_back(11'h26B);
        send_frame(8'h6B, 1'b0, 1'b1, 11, 3);
        drained("after_timeout_glitch", 3);

        ps2_data = 1'b0;
        @(negedge clk_sys);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk_sys);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk_sys);
        check("idle_glitch_busy", 32'(busy), 0);
        ps2_data = 1'b1;
        drained("idle_glitch", 3);

        send_frame(8'h1C, 1'b0, 1'b1, 6, -1);
        check("pre_reset_busy", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("mid_reset_key", 32'(ps2_key), 0);
        check("mid_reset_err", 32'(frame_err), 0);
        check("mid_reset_busy", 32'(busy), 0);
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);
        exp_q.push_back(11'h61C);
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
        drained("after_reset", 3);
        check("final_key", 32'(ps2_key), 32'h61C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
